// File: rtl/coin_acceptor_pkg.sv
// Shared constants for the coin acceptor front end: channel state codes and coin types.
package coin_acceptor_pkg;

    // Channel states; the spare code is treated as IDLE by the channel logic.
    localparam logic [1:0] CH_IDLE  = 2'd0;
    localparam logic [1:0] CH_HELD  = 2'd1;
    localparam logic [1:0] CH_JAM   = 2'd2;
    localparam logic [1:0] CH_SPARE = 2'd3;

    // Coin type as stored in the queue.
    localparam logic COIN_ONE = 1'b0;
    localparam logic COIN_TWO = 1'b1;

endpackage

// File: rtl/coin_channel_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, debounce/jam FSM, single-cycle accept strobe.
module coin_channel_debounce
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic accept,
    output logic jammed
);

    localparam int SW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int JW = $clog2(JAM_CYCLES) + 1;
    localparam logic [SW-1:0] DEB_LIM = SW'(DEBOUNCE_CYCLES);
    localparam logic [JW-1:0] JAM_LIM = JW'(JAM_CYCLES);

    logic          sync_p0;
    logic          sync_p1;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nx;
    logic [SW-1:0] stable_inc;
    logic [JW-1:0] jam_cnt;
    logic [JW-1:0] jam_nx;
    logic [JW-1:0] jam_inc;
    logic          accept_q;
    logic          accept_nx;

    assign stable_inc = (stable_cnt >= DEB_LIM) ? stable_cnt : stable_cnt + 1'b1;
    assign jam_inc    = (jam_cnt == '1) ? jam_cnt : jam_cnt + 1'b1;

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Next-state logic: stable_cnt counts highs in IDLE and lows in HELD/JAM;
    // it is kept across HELD->JAM so a release already in progress still counts.
    always_comb begin
        state_nx  = state;
        stable_nx = stable_cnt;
        jam_nx    = jam_cnt;
        accept_nx = 1'b0;
        case (state)
            CH_HELD, CH_JAM: begin
                stable_nx = sync_p1 ? '0 : stable_inc;
                if (!sync_p1 && (stable_inc >= DEB_LIM)) begin
                    state_nx  = CH_IDLE;
                    stable_nx = '0;
                    jam_nx    = '0;
                end else if (state == CH_HELD) begin
                    if (jam_cnt >= JAM_LIM) begin
                        state_nx = CH_JAM;
                    end
                    jam_nx = jam_inc;
                end
            end
            default: begin
                state_nx = CH_IDLE;
                jam_nx   = '0;
                if (!sync_p1) begin
                    stable_nx = '0;
                end else if (stable_inc >= DEB_LIM) begin
                    state_nx  = CH_HELD;
                    stable_nx = '0;
                    accept_nx = 1'b1;
                end else begin
                    stable_nx = stable_inc;
                end
            end
        endcase
    end

    // Channel state, counters and the registered accept strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CH_IDLE;
            stable_cnt <= '0;
            jam_cnt    <= '0;
            accept_q   <= 1'b0;
        end else begin
            state      <= state_nx;
            stable_cnt <= stable_nx;
            jam_cnt    <= jam_nx;
            accept_q   <= accept_nx;
        end
    end

    assign accept = accept_q;
    assign jammed = (state == CH_JAM);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced channels, a 2-entry coin queue and a gap-spaced pulse emitter.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int JAM_CYCLES      = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic one_raw,
    input  logic two_raw,
    output logic one_in,
    output logic two_in,
    output logic jam,
    output logic coin_drop
);

    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [GW-1:0] GAP_LIM = GW'(GAP_CYCLES);

    logic          acc_one;
    logic          acc_two;
    logic          jam_one;
    logic          jam_two;
    logic [1:0]    q_data;
    logic [1:0]    q_data_nx;
    logic [1:0]    q_cnt;
    logic [1:0]    q_cnt_nx;
    logic [GW-1:0] gap_cnt;
    logic          pop;
    logic          drop;
    logic          one_q;
    logic          two_q;
    logic          jam_q;
    logic          drop_q;

    coin_channel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .JAM_CYCLES     (JAM_CYCLES)
    ) u_one (
        .clk   (clk),
        .reset (reset),
        .raw   (one_raw),
        .accept(acc_one),
        .jammed(jam_one)
    );

    coin_channel_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .JAM_CYCLES     (JAM_CYCLES)
    ) u_two (
        .clk   (clk),
        .reset (reset),
        .raw   (two_raw),
        .accept(acc_two),
        .jammed(jam_two)
    );

    // Queue update: pop first (head is q_data[0]) so its slot is reusable, then push 2 Rs before 1 Rs.
    always_comb begin
        pop       = (q_cnt != 2'd0) && (gap_cnt == '0);
        q_data_nx = q_data;
        q_cnt_nx  = q_cnt;
        drop      = 1'b0;
        if (pop) begin
            q_data_nx = {1'b0, q_data[1]};
            q_cnt_nx  = q_cnt - 2'd1;
        end
        if (acc_two) begin
            if (q_cnt_nx == 2'd2) begin
                drop = 1'b1;
            end else begin
                q_data_nx[q_cnt_nx[0]] = COIN_TWO;
                q_cnt_nx = q_cnt_nx + 2'd1;
            end
        end
        if (acc_one) begin
            if (q_cnt_nx == 2'd2) begin
                drop = 1'b1;
            end else begin
                q_data_nx[q_cnt_nx[0]] = COIN_ONE;
                q_cnt_nx = q_cnt_nx + 2'd1;
            end
        end
    end

    // Queue storage, gap spacing and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_data  <= 2'b00;
            q_cnt   <= 2'd0;
            gap_cnt <= '0;
            one_q   <= 1'b0;
            two_q   <= 1'b0;
            jam_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            q_data <= q_data_nx;
            q_cnt  <= q_cnt_nx;
            jam_q  <= jam_one | jam_two;
            drop_q <= drop;
            if (pop) begin
                one_q   <= (q_data[0] == COIN_ONE);
                two_q   <= (q_data[0] == COIN_TWO);
                gap_cnt <= GAP_LIM;
            end else begin
                one_q   <= 1'b0;
                two_q   <= 1'b0;
                gap_cnt <= (gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
            end
        end
    end

    assign one_in    = one_q;
    assign two_in    = two_q;
    assign jam       = jam_q;
    assign coin_drop = drop_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: two instances (gap 2 and gap 40) share the sensor inputs and are
// compared every cycle against a behavioural model, plus directed literal expectations.
module tb_coin_acceptor;

    localparam int DEB  = 4;
    localparam int JAMC = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic one_raw = 1'b0;
    logic two_raw = 1'b0;
    logic one_a, two_a, jam_a, drop_a;
    logic one_b, two_b, jam_b, drop_b;

    int tests = 0;
    int fails = 0;
    int nprint = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(2), .JAM_CYCLES(JAMC)) dut_a (
        .clk(clk), .reset(reset), .one_raw(one_raw), .two_raw(two_raw),
        .one_in(one_a), .two_in(two_a), .jam(jam_a), .coin_drop(drop_a)
    );

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .GAP_CYCLES(40), .JAM_CYCLES(JAMC)) dut_b (
        .clk(clk), .reset(reset), .one_raw(one_raw), .two_raw(two_raw),
        .one_in(one_b), .two_in(two_b), .jam(jam_b), .coin_drop(drop_b)
    );

    // ---------------- behavioural model ----------------
    int gapv[2] = '{2, 40};
    bit dly0[2], dly1[2];
    int hi_run[2], lo_run[2], held[2];
    bit active[2], jammed[2], pend[2];
    bit mq[2][$];
    int mgap[2];
    bit m_one[2], m_two[2], m_drop[2];
    bit m_jam;

    always @(posedge clk) begin
        bit raw_now[2];
        bit v;
        bit front;
        raw_now[0] = one_raw;
        raw_now[1] = two_raw;
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                dly0[c] = 0; dly1[c] = 0; hi_run[c] = 0; lo_run[c] = 0; held[c] = 0;
                active[c] = 0; jammed[c] = 0; pend[c] = 0;
                mq[c].delete(); mgap[c] = 0; m_one[c] = 0; m_two[c] = 0; m_drop[c] = 0;
            end
            m_jam = 0;
        end else begin
            m_jam = jammed[0] | jammed[1];
            for (int k = 0; k < 2; k++) begin
                m_one[k] = 0; m_two[k] = 0; m_drop[k] = 0;
                if (mq[k].size() > 0 && mgap[k] == 0) begin
                    front = mq[k].pop_front();
                    if (front) m_two[k] = 1; else m_one[k] = 1;
                    mgap[k] = gapv[k];
                end else if (mgap[k] > 0) begin
                    mgap[k]--;
                end
                if (pend[1]) begin
                    if (mq[k].size() < 2) mq[k].push_back(1'b1); else m_drop[k] = 1;
                end
                if (pend[0]) begin
                    if (mq[k].size() < 2) mq[k].push_back(1'b0); else m_drop[k] = 1;
                end
            end
            for (int c = 0; c < 2; c++) begin
                v = dly1[c];
                dly1[c] = dly0[c];
                dly0[c] = raw_now[c];
                if (v) begin hi_run[c]++; lo_run[c] = 0; end
                else begin lo_run[c]++; hi_run[c] = 0; end
                pend[c] = 0;
                if (!active[c]) begin
                    if (hi_run[c] == DEB) begin
                        active[c] = 1; held[c] = 0; jammed[c] = 0; pend[c] = 1;
                    end
                end else if (lo_run[c] >= DEB) begin
                    active[c] = 0; jammed[c] = 0;
                end else begin
                    if (held[c] >= JAMC) jammed[c] = 1;
                    held[c]++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            tests++;
            if ({one_a, two_a, jam_a, drop_a} !== {m_one[0], m_two[0], m_jam, m_drop[0]}) begin
                fails++;
                if (nprint < 30) begin
                    nprint++;
                    $display("FAIL cycle_a t=%0t: got one/two/jam/drop=%b%b%b%b expected %b%b%b%b",
                             $time, one_a, two_a, jam_a, drop_a, m_one[0], m_two[0], m_jam, m_drop[0]);
                end
            end
            tests++;
            if ({one_b, two_b, jam_b, drop_b} !== {m_one[1], m_two[1], m_jam, m_drop[1]}) begin
                fails++;
                if (nprint < 30) begin
                    nprint++;
                    $display("FAIL cycle_b t=%0t: got one/two/jam/drop=%b%b%b%b expected %b%b%b%b",
                             $time, one_b, two_b, jam_b, drop_b, m_one[1], m_two[1], m_jam, m_drop[1]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- directed stimulus ----------------
    int f_one, f_two, n_one, n_two, j_rise, j_fall, f_drop, n_drop, mf_one, mj_rise;

    task automatic watch(input int sel, input logic [63:0] p1, input logic [63:0] p2, input int plen,
                         input logic o, input logic t, input int rel_at, input int rst_at, input int n);
        logic po, pt, pj, pd;
        f_one = -1; f_two = -1; n_one = 0; n_two = 0; j_rise = -1; j_fall = -1;
        f_drop = -1; n_drop = 0; mf_one = -1; mj_rise = -1;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k < plen) begin one_raw = p1[k]; two_raw = p2[k]; end
            else if (k < rel_at) begin one_raw = o; two_raw = t; end
            else begin one_raw = 1'b0; two_raw = 1'b0; end
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                check("reset_async_clear",
                      int'({one_a, two_a, jam_a, drop_a, one_b, two_b, jam_b, drop_b}), 0);
            end else begin
                reset = 1'b1;
            end
            @(posedge clk);
            #1;
            po = sel ? one_b : one_a;
            pt = sel ? two_b : two_a;
            pj = sel ? jam_b : jam_a;
            pd = sel ? drop_b : drop_a;
            if (po) begin n_one++; if (f_one < 0) f_one = k; end
            if (pt) begin n_two++; if (f_two < 0) f_two = k; end
            if (pd) begin n_drop++; if (f_drop < 0) f_drop = k; end
            if (pj && j_rise < 0) j_rise = k;
            if (!pj && j_rise >= 0 && j_fall < 0) j_fall = k;
            if (m_one[sel] && mf_one < 0) mf_one = k;
            if (m_jam && mj_rise < 0) mj_rise = k;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        one_raw = 1'b0;
        two_raw = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input int c, input logic v);
        if (c == 0) one_raw = v; else two_raw = v;
    endtask

    task automatic drive_ch(input int c, input int iters);
        int g, b, h, r;
        for (int i = 0; i < iters; i++) begin
            g = $urandom_range(0, 15);
            b = $urandom_range(0, 5);
            h = ($urandom_range(0, 19) == 0) ? $urandom_range(262, 290) : $urandom_range(1, 30);
            r = $urandom_range(0, 5);
            repeat (g) begin set_raw(c, 1'b0); @(negedge clk); end
            repeat (b) begin set_raw(c, 1'($urandom_range(0, 1))); @(negedge clk); end
            repeat (h) begin set_raw(c, 1'b1); @(negedge clk); end
            repeat (r) begin set_raw(c, 1'($urandom_range(0, 1))); @(negedge clk); end
        end
        set_raw(c, 1'b0);
    endtask

    initial begin
        logic [63:0] pat;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pat;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'({one_a, two_a, jam_a, drop_a, one_b, two_b, jam_b, drop_b}), 0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // 1: single clean press
        watch(0, 64'd0, 64'd0, 0, 1'b1, 1'b0, 20, -1, 30);
        check("t1_one_at", f_one, 7);
        check("t1_one_cnt", n_one, 1);
        check("t1_two_cnt", n_two, 0);
        check("t1_model_at", mf_one, 7);
        idle(12);

        // 2: bounce 1,0,1,0 then stable high from cycle 4
        watch(0, 64'b0101, 64'd0, 4, 1'b1, 1'b0, 24, -1, 34);
        check("t2_one_at", f_one, 11);
        check("t2_one_cnt", n_one, 1);

        // 3: both rise together, 2 Rs first then 1 Rs after the gap
        watch(0, 64'd0, 64'd0, 0, 1'b1, 1'b1, 20, -1, 34);
        check("t3_two_at", f_two, 7);
        check("t3_one_at", f_one, 10);
        check("t3_cnt", n_one + n_two, 2);
        idle(100);

        // 4: gap 40 instance, coins every 12 cycles overflow the queue on the fourth
        pat = '0;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 6; j++) pat[c*12 + j] = 1'b1;
        watch(1, pat, 64'd0, 48, 1'b0, 1'b0, 48, -1, 140);
        check("t4_first_at", f_one, 7);
        check("t4_pulses", n_one, 3);
        check("t4_drop_at", f_drop, 42);
        check("t4_drop_cnt", n_drop, 1);
        idle(20);

        // 5: long hold -> single pulse, jam, release clears jam
        watch(0, 64'd0, 64'd0, 0, 1'b0, 1'b1, 300, -1, 320);
        check("t5_two_at", f_two, 7);
        check("t5_two_cnt", n_two, 1);
        check("t5_jam_rise", j_rise, 7 + JAMC);
        check("t5_jam_fall", j_fall, 300 + DEB + 2);
        check("t5_model_jam", mj_rise, 7 + JAMC);
        idle(10);

        // 6: reset during a pending coin, then a fresh coin
        watch(0, 64'd0, 64'd0, 0, 1'b1, 1'b0, 6, 6, 30);
        check("t6_no_one", n_one, 0);
        check("t6_no_two", n_two, 0);
        watch(0, 64'd0, 64'd0, 0, 1'b1, 1'b0, 20, -1, 30);
        check("t6_fresh_at", f_one, 7);
        idle(100);

        // randomized presses on both channels
        fork
            drive_ch(0, 30);
            drive_ch(1, 30);
        join
        idle(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
